// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of every signal that crosses the mmio_bus_arbiter boundary.
// The two request ports come in from the masters and the strobe bus goes
// out to the mmio_sys slot controller.
// 'slave' is the arbiter's view of the bundle; 'master' is the view of
// whatever drives the requests and models the slot.
interface mmio_bus_arbiter_if #(
  parameter int AW = 21,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m1_req;
  logic          m0_wr;
  logic          m1_wr;
  logic [AW-1:0] m0_addr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m0_wr_data;
  logic [DW-1:0] m1_wr_data;
  logic          m0_lock;
  logic          m0_ack;
  logic          m1_ack;
  logic [DW-1:0] m0_rd_data;
  logic [DW-1:0] m1_rd_data;
  logic [1:0]    gnt;
  logic          mmio_cs;
  logic          mmio_wr;
  logic          mmio_rd;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data;
  logic [DW-1:0] mmio_rd_data;

  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
           m0_wr_data, m1_wr_data, m0_lock, mmio_rd_data,
    output m0_ack, m1_ack, m0_rd_data, m1_rd_data, gnt,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );

  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
           m0_wr_data, m1_wr_data, m0_lock, mmio_rd_data,
    input  m0_ack, m1_ack, m0_rd_data, m1_rd_data, gnt,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the FPro MMIO bus.
// Each granted request produces exactly one single-cycle bus strobe,
// followed by a one-cycle ack to the winner. Master 0 may lock the bus
// so that its read-modify-write sequences cannot be split by master 1.
module mmio_bus_arbiter #(
  parameter int AW = 21,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  mmio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_win;
  logic          r_lockHold;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wrData;
  logic [DW-1:0] r_rdData0;
  logic [DW-1:0] r_rdData1;
  logic [1:0]    r_gnt;
  logic          r_cs;
  logic          r_mmioWr;
  logic          r_mmioRd;
  logic          r_ack0;
  logic          r_ack1;

  logic          w_grant0;
  logic          w_grant1;
  logic          w_selWr;
  logic [AW-1:0] w_selAddr;
  logic [DW-1:0] w_selWrData;

  // Pick the next winner: a held lock reserves the bus for master 0,
  // a tie goes to whichever master was not served last (r_last = 1 means master 1).
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_lockHold) begin
      w_grant0 = bus.m0_req;
    end else if (bus.m0_req && bus.m1_req) begin
      w_grant0 = r_last;
      w_grant1 = !r_last;
    end else begin
      w_grant0 = bus.m0_req;
      w_grant1 = bus.m1_req;
    end
  end

  // Route the winning master's command fields toward the bus registers.
  always_comb begin
    w_selWr     = w_grant1 ? bus.m1_wr      : bus.m0_wr;
    w_selAddr   = w_grant1 ? bus.m1_addr    : bus.m0_addr;
    w_selWrData = w_grant1 ? bus.m1_wr_data : bus.m0_wr_data;
  end

  // Sequencer: IDLE latches a request, ISSUE strobes the bus for one cycle and
  // captures read data, DONE closes the transaction and updates fairness/lock.
  // Strobes and acks are registered and default low, so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_lockHold <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wrData   <= '0;
      r_rdData0  <= '0;
      r_rdData1  <= '0;
      r_gnt      <= 2'b00;
      r_cs       <= 1'b0;
      r_mmioWr   <= 1'b0;
      r_mmioRd   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
    end else begin
      r_cs     <= 1'b0;
      r_mmioWr <= 1'b0;
      r_mmioRd <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_win    <= w_grant1;
            r_wr     <= w_selWr;
            r_addr   <= w_selAddr;
            r_wrData <= w_selWrData;
            r_gnt    <= {w_grant1, w_grant0};
            r_cs     <= 1'b1;
            r_mmioWr <= w_selWr;
            r_mmioRd <= !w_selWr;
            r_state  <= ISSUE;
          end else if (r_lockHold && !bus.m0_lock && !bus.m0_req) begin
            r_lockHold <= 1'b0;
          end
        end
        ISSUE: begin
          if (!r_wr) begin
            if (r_win) begin
              r_rdData1 <= bus.mmio_rd_data;
            end else begin
              r_rdData0 <= bus.mmio_rd_data;
            end
          end
          r_ack0  <= !r_win;
          r_ack1  <= r_win;
          r_state <= DONE;
        end
        DONE: begin
          r_last     <= r_win;
          r_lockHold <= !r_win && bus.m0_lock;
          r_gnt      <= 2'b00;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.mmio_cs      = r_cs;
  assign bus.mmio_wr      = r_mmioWr;
  assign bus.mmio_rd      = r_mmioRd;
  assign bus.mmio_addr    = r_addr;
  assign bus.mmio_wr_data = r_wrData;
  assign bus.m0_ack       = r_ack0;
  assign bus.m1_ack       = r_ack1;
  assign bus.m0_rd_data   = r_rdData0;
  assign bus.m1_rd_data   = r_rdData1;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter. Directed transactions push their expected
// bus cycle and ack into a queue; a monitor running on the falling edge
// matches every strobe and ack against the head of that queue.
module tb_mmio_bus_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;

  logic clk;
  logic reset;

  mmio_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mmio_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int            master;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            checkGap;
  } exp_t;

  exp_t expQ[$];
  int   nCompared    = 0;
  int   nMismatched  = 0;
  int   cycleCount   = 0;
  int   lastAckCycle = -100;
  int   strobeCycle  = -100;
  logic prevCs       = 1'b0;

  // Slot model: one fixed register at 0xC0, everything else echoes its address.
  assign bus.mmio_rd_data = (bus.mmio_addr == 21'h000C0) ? 32'hDEADBEEF
                          : (32'h5A5A0000 | {11'd0, bus.mmio_addr});

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to measure latency and ack spacing.
  always @(posedge clk) cycleCount++;

  // Hard stop in case the DUT wedges somewhere the bounded waits do not cover.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  task automatic pushExp(input int master, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input bit gap);
    exp_t e;
    e.master   = master;
    e.wr       = wr;
    e.addr     = addr;
    e.wdata    = wdata;
    e.rdata    = rdata;
    e.checkGap = gap;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int master, input logic req, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (master == 0) begin
      bus.m0_req     = req;
      bus.m0_wr      = wr;
      bus.m0_addr    = addr;
      bus.m0_wr_data = wdata;
    end else begin
      bus.m1_req     = req;
      bus.m1_wr      = wr;
      bus.m1_addr    = addr;
      bus.m1_wr_data = wdata;
    end
  endtask

  task automatic dropReq(input int master);
    if (master == 0) bus.m0_req = 1'b0;
    else             bus.m1_req = 1'b0;
  endtask

  // Waits on falling edges for the given master's ack; returns the cycle it was seen.
  task automatic waitAck(input int master, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((master == 0 && bus.m0_ack) || (master == 1 && bus.m1_ack)) begin
        seen = 1'b1;
        cyc  = cycleCount;
      end
    end
    checkOutput($sformatf("waitAck_m%0d", master), {63'd0, seen}, 64'd1);
  endtask

  task automatic waitStrobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mmio_cs) seen = 1'b1;
    end
    checkOutput("waitStrobe", {63'd0, seen}, 64'd1);
  endtask

  // Monitor: every strobe must match the queue head; every ack pops it
  // after checking owner, latency, read data and (when asked) spacing.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.mmio_cs) begin
        checkOutput("csSingleCycle", {63'd0, prevCs}, 64'd0);
        checkOutput("strobeQueued", {63'd0, expQ.size() > 0}, 64'd1);
        if (expQ.size() > 0) begin
          e = expQ[0];
          checkOutput("strobeGnt", {62'd0, bus.gnt}, (e.master == 0) ? 64'd1 : 64'd2);
          checkOutput("strobeAddr", {43'd0, bus.mmio_addr}, {43'd0, e.addr});
          checkOutput("strobeWrRd", {62'd0, bus.mmio_wr, bus.mmio_rd}, {62'd0, e.wr, !e.wr});
          if (e.wr) checkOutput("strobeWrData", {32'd0, bus.mmio_wr_data}, {32'd0, e.wdata});
        end
        strobeCycle = cycleCount;
      end
      if (bus.m0_ack || bus.m1_ack) begin
        checkOutput("ackQueued", {63'd0, expQ.size() > 0}, 64'd1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("ackOwner", {62'd0, bus.m1_ack, bus.m0_ack}, (e.master == 0) ? 64'd1 : 64'd2);
          checkOutput("ackGnt", {62'd0, bus.gnt}, (e.master == 0) ? 64'd1 : 64'd2);
          checkOutput("ackLatency", 64'(cycleCount), 64'(strobeCycle + 1));
          checkOutput("rdData", (e.master == 0) ? {32'd0, bus.m0_rd_data} : {32'd0, bus.m1_rd_data},
                      {32'd0, e.rdata});
          if (e.checkGap) checkOutput("ackSpacing", 64'(cycleCount - lastAckCycle), 64'd3);
        end
        lastAckCycle = cycleCount;
      end
      prevCs = bus.mmio_cs;
    end else begin
      prevCs = 1'b0;
    end
  end

  // Directed stimulus sequence.
  initial begin
    int c;
    int relCycle;
    bus.m0_lock = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rstGnt", {62'd0, bus.gnt}, 64'd0);
    checkOutput("rstStrobes", {61'd0, bus.mmio_cs, bus.mmio_wr, bus.mmio_rd}, 64'd0);
    checkOutput("rstAcks", {62'd0, bus.m1_ack, bus.m0_ack}, 64'd0);
    checkOutput("rstAddr", {43'd0, bus.mmio_addr}, 64'd0);
    checkOutput("rstWrData", {32'd0, bus.mmio_wr_data}, 64'd0);
    checkOutput("rstRd0", {32'd0, bus.m0_rd_data}, 64'd0);
    checkOutput("rstRd1", {32'd0, bus.m1_rd_data}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single read by master 0 from the fixed slot register.
    pushExp(0, 1'b0, 21'h000C0, 32'h0, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 21'h000C0, 32'h11111111);
    waitAck(0, c);
    dropReq(0);
    repeat (2) @(negedge clk);

    // Master 1 read, then a write that must leave its read data alone.
    pushExp(1, 1'b0, 21'h00100, 32'h0, 32'h5A5A0100, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 21'h00100, 32'h0);
    waitAck(1, c);
    dropReq(1);
    repeat (2) @(negedge clk);
    pushExp(1, 1'b1, 21'h00080, 32'h000000A5, 32'h5A5A0100, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 21'h00080, 32'h000000A5);
    waitAck(1, c);
    dropReq(1);
    repeat (2) @(negedge clk);

    // Tie: both masters hold requests for six transactions; master 0 goes first.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) pushExp(0, 1'b0, 21'h00200, 32'h0, 32'h5A5A0200, k > 0);
      else            pushExp(1, 1'b0, 21'h00300, 32'h0, 32'h5A5A0300, 1'b1);
    end
    applyStimulus(0, 1'b1, 1'b0, 21'h00200, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 21'h00300, 32'h0);
    for (int k = 0; k < 6; k++) waitAck(k % 2, c);
    dropReq(0);
    dropReq(1);
    repeat (3) @(negedge clk);

    // Lock: master 0 keeps the bus for three transactions, even across a gap
    // in its own requests, while master 1 requests throughout.
    pushExp(0, 1'b0, 21'h00400, 32'h0, 32'h5A5A0400, 1'b0);
    pushExp(0, 1'b0, 21'h00400, 32'h0, 32'h5A5A0400, 1'b0);
    pushExp(0, 1'b0, 21'h00400, 32'h0, 32'h5A5A0400, 1'b1);
    pushExp(1, 1'b0, 21'h00500, 32'h0, 32'h5A5A0500, 1'b1);
    pushExp(0, 1'b0, 21'h00400, 32'h0, 32'h5A5A0400, 1'b1);
    bus.m0_lock = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 21'h00400, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 21'h00500, 32'h0);
    waitAck(0, c);
    dropReq(0);
    repeat (5) @(negedge clk);
    bus.m0_req = 1'b1;
    waitAck(0, c);
    waitAck(0, c);
    bus.m0_lock = 1'b0;
    waitAck(1, c);
    dropReq(1);
    waitAck(0, c);
    dropReq(0);
    repeat (3) @(negedge clk);

    // Request withdrawn during the strobe still completes and acks.
    pushExp(0, 1'b1, 21'h00700, 32'hCAFEF00D, 32'h5A5A0400, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 21'h00700, 32'hCAFEF00D);
    waitStrobe();
    dropReq(0);
    waitAck(0, c);
    repeat (2) @(negedge clk);

    // Reset during the strobe cycle aborts; the held request is re-served after release.
    pushExp(0, 1'b0, 21'h00600, 32'h0, 32'h5A5A0600, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 21'h00600, 32'h0);
    waitStrobe();
    #2 reset = 1'b0;
    #1;
    checkOutput("abortStrobes", {61'd0, bus.mmio_cs, bus.mmio_wr, bus.mmio_rd}, 64'd0);
    checkOutput("abortGnt", {62'd0, bus.gnt}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abortNoAck", {62'd0, bus.m1_ack, bus.m0_ack}, 64'd0);
    end
    reset = 1'b1;
    relCycle = cycleCount;
    waitAck(0, c);
    checkOutput("reissueLatency", 64'(c), 64'(relCycle + 2));
    dropReq(0);
    repeat (2) @(negedge clk);

    // Idle hold: after a write to 0x40 the bus stays quiet and keeps its address.
    pushExp(1, 1'b1, 21'h00040, 32'h00001234, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 21'h00040, 32'h00001234);
    waitAck(1, c);
    dropReq(1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("idleCs", {63'd0, bus.mmio_cs}, 64'd0);
      checkOutput("idleAddr", {43'd0, bus.mmio_addr}, 64'h40);
    end

    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Two-master arbiter and sequencer for the FPro MMIO bus that feeds the `mmio_sys` slot controller. It lets the CPU (master 0) and a second hardware master (master 1, e.g. a UART debug bridge or autonomous sensor poller) share one MMIO bus. It latches each request, issues exactly one single-cycle bus strobe, captures read data, and returns a one-cycle acknowledge. Arbitration is round-robin, with an optional lock that lets master 0 perform atomic read-modify-write sequences.

## Interface

Parameters:
- `AW`, 21: MMIO address width; matches `mmio_addr`.
- `DW`, 32: MMIO data width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `m0_req`, `m1_req`  in  1  request; held high until the matching ack.
- `m0_wr`, `m1_wr`  in  1  1 = write, 0 = read; valid while req is high.
- `m0_addr`, `m1_addr`  in  AW  target MMIO address.
- `m0_wr_data`, `m1_wr_data`  in  DW  write data.
- `m0_lock`  in  1  master 0 keeps bus ownership across consecutive transactions.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rd_data`, `m1_rd_data`  out  DW  registered read data; valid from the ack cycle until that master's next ack.
- `gnt`  out  2  one-hot current owner; 00 when idle.
- `mmio_cs`, `mmio_wr`, `mmio_rd`  out  1  bus strobes to the MMIO controller.
- `mmio_addr`  out  AW  registered bus address.
- `mmio_wr_data`  out  DW  registered bus write data.
- `mmio_rd_data`  in  DW  bus read data; combinational from the slot, valid in the strobe cycle.

## Operation

- FSM has three states: IDLE, ISSUE, DONE.
- IDLE:
  - Samples `m0_req` and `m1_req`.
  - If any request is high, selects a winner, latches that master's `wr`, `addr` and `wr_data` into the bus registers, sets `gnt`, and moves to ISSUE.
  - With no request it stays in IDLE.
- Winner selection:
  - If `lock_hold` is set, only master 0 may win; master 1 waits even if master 0 is not requesting.
  - Otherwise, if only one master requests, it wins.
  - If both request, the master not granted last wins (round-robin pointer `last`).
- ISSUE:
  - Asserts `mmio_cs` = 1, plus `mmio_wr` = latched wr or `mmio_rd` = !latched wr, for exactly this one cycle.
  - On a read, captures `mmio_rd_data` into the winner's `rd_data` register at the end of the cycle.
  - On a write, `rd_data` is unchanged.
  - Moves to DONE.
- DONE:
  - Pulses the winner's ack for one cycle.
  - Sets `last` to the winner.
  - If the winner is master 0 and `m0_lock` = 1, sets `lock_hold`; otherwise clears it.
  - Clears `gnt` and moves to IDLE.
- Request handling: requests are sampled only in IDLE. A master that keeps req high in the cycle after its ack starts a new transaction.
- Lock release: when `m0_lock` drops, the next DONE clears `lock_hold`. If master 0 releases lock while idle, `lock_hold` clears in IDLE on the first cycle `m0_lock` = 0 and no `m0_req` is present.
- Bus registers hold their last values between transactions. Strobes are 0 outside ISSUE.

## Timing

- Latency: req high at IDLE edge N; strobe in cycle N+1; ack in cycle N+2; `rd_data` valid in N+2.
- Throughput: one transaction per 3 cycles. Back-to-back requests from alternating masters interleave strictly.
- Reset values:
  - FSM = IDLE, `last` = master 1 (so master 0 wins the first tie), `lock_hold` = 0.
  - `gnt` = 00, all strobes and acks = 0, `mmio_addr` = 0, `mmio_wr_data` = 0, `m0_rd_data` = `m1_rd_data` = 0.
- Reset asserted mid-transaction (ISSUE or DONE): outputs clear immediately and asynchronously; no ack is ever issued for the aborted request. After release, the master must still be holding req to be re-served.
- Simultaneous requests in IDLE: exactly one `gnt` bit is set; the other master is served in the next arbitration, unless `lock_hold` is set.
- A request dropped before its ack (protocol violation) does not abort the transaction; it completes and acks anyway.

## Test plan

- Single read: reset, then `m0_req` = 1, `m0_wr` = 0, `m0_addr` = 0x000C0 with the slot returning 0xDEADBEEF -> `mmio_rd` = 1, `mmio_cs` = 1 for one cycle at N+1; `m0_ack` pulses at N+2; `m0_rd_data` = 0xDEADBEEF; `gnt` = 01 in N+1..N+2.
- Single write from master 1: `m1_addr` = 0x00080, `m1_wr_data` = 0x000000A5 -> `mmio_wr` = 1 with those values for one cycle; `m1_ack` at N+2; `m1_rd_data` unchanged.
- Tie: both req high continuously for 6 transactions -> acks alternate m0, m1, m0, m1, m0, m1, each exactly 3 cycles apart.
- Lock: `m0_lock` = 1 with 3 m0 transactions while `m1_req` = 1 throughout -> all 3 go to m0 and m1 gets nothing. After `m0_lock` drops, m1 is served before m0's next transaction.
- Reset mid-ISSUE: assert `reset` = 0 during the strobe cycle -> strobes, `gnt` and acks go to 0 immediately and no ack follows. After release, with req still high, the transaction reissues and acks 2 cycles after the first IDLE edge.
- Idle hold: no requests for 10 cycles after a write to 0x00040 -> `mmio_cs` stays 0 and `mmio_addr` stays 0x00040.
